// File: rtl/mux_defs.sv
// Shared constants for the N:1 stream multiplexer and its round-robin arbiter.
package mux_defs;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin scan: picks the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// CHANNELS:1 valid/ready stream mux with a single output register, select or round-robin grant.
// Define MUX_N_1_STREAM_STATS_EN to enable the saturating accepted-output counter.
module mux_n_1_stream
    import mux_defs::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_chan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    logic             free;
    logic             in_xfer;
    logic             out_xfer;
    logic [SEL_W-1:0] ptr;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;

    rr_arbiter #(
        .N     (CHANNELS),
        .PTR_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    assign free     = !out_valid || out_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = (int'(sel) < CHANNELS);
            gnt_idx   = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        if (gnt_valid) begin
            in_ready[gnt_idx] = free;
        end
    end

    assign in_xfer = gnt_valid && in_valid[gnt_idx] && free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_chan  <= gnt_idx;
            // Select-mode grants leave the round-robin position untouched.
            if (mode == MODE_RR) begin
                ptr <= (gnt_idx == LAST_CHAN) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_N_1_STREAM_STATS_EN
    logic [XFER_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_xfer && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign xfer_count = cnt;
`else
    assign xfer_count = '0;
`endif

endmodule
